// File: rtl/fft8_serial.sv
// fft8_serial: 8-point radix-2 DIT FFT built around one time-shared butterfly.
// One frame is loaded in bit-reversed order, transformed in place over twelve
// butterfly cycles (each stage halves the data), then streamed out in natural
// order with a valid/ready handshake. Every bin is X[k]/8, saturated to 16 bits.
module fft8_serial #(
    parameter bit OFFSET_BINARY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in_0,
    input  logic [15:0] in_1,
    input  logic [15:0] in_2,
    input  logic [15:0] in_3,
    input  logic [15:0] in_4,
    input  logic [15:0] in_5,
    input  logic [15:0] in_6,
    input  logic [15:0] in_7,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_idx,
    output logic [15:0] out_re,
    output logic [15:0] out_im
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BFLY, S_OUT} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_s, r_b;
    logic [2:0]         r_idx;
    logic signed [15:0] r_re [8];
    logic signed [15:0] r_im [8];
    logic signed [15:0] r_out_re, r_out_im;

    logic [15:0]        w_x   [8];
    logic signed [15:0] w_smp [8];
    logic [2:0]         w_top, w_bot;
    logic [1:0]         w_k;
    logic signed [15:0] w_w_re, w_w_im;
    logic signed [15:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [33:0] w_pr, w_pi;
    logic signed [17:0] w_t_re, w_t_im;
    logic signed [18:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic               w_last_bfly, w_hs;

    function automatic logic [2:0] bitrev3(input logic [2:0] j);
        return {j[0], j[1], j[2]};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)       return 16'sh7FFF;
        else if (v < -19'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    assign w_x = '{in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7};

    assign w_last_bfly = (r_s == 2'd2) && (r_b == 2'd3);
    assign w_hs        = out_valid && out_ready;

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_idx   = r_idx;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;

    // Convert raw samples to signed values (offset-binary flips the MSB).
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            if (OFFSET_BINARY) w_smp[j] = {~w_x[j][15], w_x[j][14:0]};
            else               w_smp[j] = w_x[j];
        end
    end

    // Butterfly addressing and twiddle selection for stage s, butterfly b.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_top = 3'd0;
        w_bot = 3'd0;
        w_k   = 2'd0;
        case (r_s)
            2'd0: begin
                w_top = {r_b, 1'b0};
                w_bot = {r_b, 1'b1};
            end
            2'd1: begin
                w_top = {r_b[1], 1'b0, r_b[0]};
                w_bot = {r_b[1], 1'b1, r_b[0]};
                w_k   = {r_b[0], 1'b0};
            end
            default: begin
                w_top = {1'b0, r_b};
                w_bot = {1'b1, r_b};
                w_k   = r_b;
            end
        endcase
        case (w_k)
            2'd0:    begin w_w_re =  16'sd16384; w_w_im =  16'sd0;     end
            2'd1:    begin w_w_re =  16'sd11585; w_w_im = -16'sd11585; end
            2'd2:    begin w_w_re =  16'sd0;     w_w_im = -16'sd16384; end
            default: begin w_w_re = -16'sd11585; w_w_im = -16'sd11585; end
        endcase
    end

    // Complex multiply B*W in Q1.14 (floor), then scaled and saturated A+t / A-t.
    always_comb begin
        w_a_re   = r_re[w_top];
        w_a_im   = r_im[w_top];
        w_b_re   = r_re[w_bot];
        w_b_im   = r_im[w_bot];
        w_pr     = 34'(w_b_re) * 34'(w_w_re) - 34'(w_b_im) * 34'(w_w_im);
        w_pi     = 34'(w_b_re) * 34'(w_w_im) + 34'(w_b_im) * 34'(w_w_re);
        w_t_re   = 18'(w_pr >>> 14);
        w_t_im   = 18'(w_pi >>> 14);
        w_sum_re = 19'(w_a_re) + 19'(w_t_re);
        w_sum_im = 19'(w_a_im) + 19'(w_t_im);
        w_dif_re = 19'(w_a_re) - 19'(w_t_re);
        w_dif_im = 19'(w_a_im) - 19'(w_t_im);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic; start only matters while idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = S_BFLY;
            S_BFLY: if (w_last_bfly) w_next = S_OUT;
            S_OUT:  if (w_hs && (r_idx == 3'd7)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Register file, butterfly counters and registered output bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is reset so an aborted frame can never leak old data.
            for (int j = 0; j < 8; j++) begin
                r_re[j] <= '0;
                r_im[j] <= '0;
            end
            r_s      <= 2'd0;
            r_b      <= 2'd0;
            r_idx    <= 3'd0;
            r_out_re <= '0;
            r_out_im <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    for (int j = 0; j < 8; j++) begin
                        r_re[j] <= w_smp[bitrev3(3'(j))];
                        r_im[j] <= '0;
                    end
                    r_s <= 2'd0;
                    r_b <= 2'd0;
                end
                S_BFLY: begin
                    r_re[w_top] <= sat16(w_sum_re >>> 1);
                    r_im[w_top] <= sat16(w_sum_im >>> 1);
                    r_re[w_bot] <= sat16(w_dif_re >>> 1);
                    r_im[w_bot] <= sat16(w_dif_im >>> 1);
                    r_b <= r_b + 2'd1;
                    if (r_b == 2'd3) r_s <= r_s + 2'd1;
                    // The last butterfly touches entries 3 and 7, so entry 0 is already final.
                    if (w_last_bfly) begin
                        r_idx    <= 3'd0;
                        r_out_re <= r_re[0];
                        r_out_im <= r_im[0];
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        r_idx    <= r_idx + 3'd1;
                        r_out_re <= r_re[r_idx + 3'd1];
                        r_out_im <= r_im[r_idx + 3'd1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_serial.sv
// Directed bench for fft8_serial: one signed-input instance and one
// offset-binary instance share stimulus; each test picks which one to check.
`timescale 1ns/1ps
module tb_fft8_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        out_ready;
    logic [15:0] in_v [8];

    logic        busy0, valid0, busy1, valid1;
    logic [2:0]  idx0, idx1;
    logic [15:0] re0, im0, re1, im1;

    logic        m_busy, m_valid;
    logic [2:0]  m_idx;
    logic [15:0] m_re, m_im;
    bit          g_sel;

    int n_checks = 0;
    int n_pass   = 0;
    int got_idx [8];
    int got_re  [8];
    int got_im  [8];
    int got_n;
    int lat;

    always #5 clk = ~clk;

    fft8_serial #(.OFFSET_BINARY(1'b0)) u_dut_sb (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
        .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
        .busy(busy0), .out_valid(valid0), .out_ready(out_ready),
        .out_idx(idx0), .out_re(re0), .out_im(im0)
    );

    fft8_serial #(.OFFSET_BINARY(1'b1)) u_dut_ob (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
        .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
        .busy(busy1), .out_valid(valid1), .out_ready(out_ready),
        .out_idx(idx1), .out_re(re1), .out_im(im1)
    );

    always_comb begin
        m_busy  = g_sel ? busy1  : busy0;
        m_valid = g_sel ? valid1 : valid0;
        m_idx   = g_sel ? idx1   : idx0;
        m_re    = g_sel ? re1    : re0;
        m_im    = g_sel ? im1    : im0;
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic start_frame(input int x [8]);
        @(posedge clk); #1;
        for (int j = 0; j < 8; j++) in_v[j] = 16'(x[j]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid();
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic collect();
        got_n = 0;
        for (int k = 0; k < 8; k++) begin
            got_idx[k] = -1; got_re[k] = -99999; got_im[k] = -99999;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got_n < 8; c++) begin
            if (m_valid) begin
                got_idx[got_n] = int'(m_idx);
                got_re[got_n]  = int'($signed(m_re));
                got_im[got_n]  = int'($signed(m_im));
                got_n++;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int j = 0; j < 8; j++) in_v[j] = 16'h0000;
        #12;
        n_checks++;
        if ({busy0, valid0, idx0, re0, im0} !== 38'd0)
            $display("FAIL reset_sb: got busy=%b valid=%b idx=%0d re=%0d im=%0d, want all 0", busy0, valid0, idx0, re0, im0);
        else n_pass++;
        n_checks++;
        if ({busy1, valid1, idx1, re1, im1} !== 38'd0)
            $display("FAIL reset_ob: got busy=%b valid=%b idx=%0d re=%0d im=%0d, want all 0", busy1, valid1, idx1, re1, im1);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy0, valid0);
        else n_pass++;
    endtask

    task automatic test_impulse();
        g_sel = 1'b0;
        start_frame('{8000, 0, 0, 0, 0, 0, 0, 0});
        n_checks++;
        if (m_busy !== 1'b1) $display("FAIL impulse_busy: got %b, want 1", m_busy);
        else n_pass++;
        wait_valid();
        n_checks++;
        if (lat !== 13) $display("FAIL impulse_latency: got %0d edges after start edge, want 13", lat);
        else n_pass++;
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== 1000 || got_im[k] !== 0)
                $display("FAIL impulse_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (1000,0)", k, got_idx[k], got_re[k], got_im[k], k);
            else n_pass++;
        end
        n_checks++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL impulse_done: got busy=%b valid=%b, want 0 0", m_busy, m_valid);
        else n_pass++;
    endtask

    task automatic test_dc();
        g_sel = 1'b0;
        start_frame('{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096});
        wait_valid();
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== ((k == 0) ? 4096 : 0) || got_im[k] !== 0)
                $display("FAIL dc_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (%0d,0)", k, got_idx[k], got_re[k], got_im[k], k, (k == 0) ? 4096 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_nyquist();
        g_sel = 1'b0;
        start_frame('{4096, -4096, 4096, -4096, 4096, -4096, 4096, -4096});
        wait_valid();
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== ((k == 4) ? 4096 : 0) || got_im[k] !== 0)
                $display("FAIL nyquist_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (%0d,0)", k, got_idx[k], got_re[k], got_im[k], k, (k == 4) ? 4096 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_offset_binary();
        g_sel = 1'b1;
        start_frame('{32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000});
        wait_valid();
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== 0 || got_im[k] !== 0)
                $display("FAIL ob_mid_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (0,0)", k, got_idx[k], got_re[k], got_im[k], k);
            else n_pass++;
        end
        start_frame('{32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF});
        wait_valid();
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== ((k == 0) ? 32767 : 0) || got_im[k] !== 0)
                $display("FAIL ob_full_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (%0d,0)", k, got_idx[k], got_re[k], got_im[k], k, (k == 0) ? 32767 : 0);
            else n_pass++;
        end
        g_sel = 1'b0;
    endtask

    // Impulse at x[1] gives 1000*W8^k with floor rounding, so every bin differs.
    task automatic test_backpressure();
        int er [8] = '{1000, 707, 0, -708, -1000, -707, 0, 707};
        int ei [8] = '{0, -708, -1000, -708, 0, 707, 1000, 707};
        int stalls = 0;
        g_sel = 1'b0;
        start_frame('{0, 8000, 0, 0, 0, 0, 0, 0});
        wait_valid();
        got_n = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got_n < 8; c++) begin
            if (m_valid) begin
                if (m_idx == 3'd3 && stalls < 5) begin
                    out_ready = 1'b0;
                    n_checks++;
                    if (int'($signed(m_re)) !== -708 || int'($signed(m_im)) !== -708)
                        $display("FAIL stall_hold%0d: got idx=%0d (%0d,%0d), want idx=3 (-708,-708)", stalls, m_idx, $signed(m_re), $signed(m_im));
                    else n_pass++;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    got_idx[got_n] = int'(m_idx);
                    got_re[got_n]  = int'($signed(m_re));
                    got_im[got_n]  = int'($signed(m_im));
                    got_n++;
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (stalls !== 5 || got_n !== 8)
            $display("FAIL stall_count: got stalls=%0d bins=%0d, want 5 8", stalls, got_n);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== er[k] || got_im[k] !== ei[k])
                $display("FAIL bp_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (%0d,%0d)", k, got_idx[k], got_re[k], got_im[k], k, er[k], ei[k]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start();
        g_sel = 1'b0;
        start_frame('{8000, 0, 0, 0, 0, 0, 0, 0});
        repeat (3) begin @(posedge clk); #1; end
        for (int j = 0; j < 8; j++) in_v[j] = 16'd4096;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid();
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== 1000 || got_im[k] !== 0)
                $display("FAIL bfly_start_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (1000,0)", k, got_idx[k], got_re[k], got_im[k], k);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_busy !== 1'b0) $display("FAIL bfly_start_latched: got busy=%b, want 0", m_busy);
        else n_pass++;
    endtask

    task automatic test_start_at_last();
        bit found = 1'b0;
        g_sel = 1'b0;
        start_frame('{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096});
        wait_valid();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_valid && m_idx == 3'd7) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (!found || m_busy !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL last_hs_start: got found=%b busy=%b valid=%b, want 1 0 0", found, m_busy, m_valid);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (m_busy !== 1'b0) $display("FAIL last_hs_start_late: got busy=%b, want 0", m_busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        g_sel = 1'b0;
        start_frame('{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096});
        wait_valid();
        collect();
        // Now in the IDLE cycle right after the bin-7 handshake.
        for (int j = 0; j < 8; j++) in_v[j] = (j == 0) ? 16'd8000 : 16'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (m_busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b, want 1", m_busy);
        else n_pass++;
        wait_valid();
        n_checks++;
        if (lat !== 13) $display("FAIL b2b_latency: got %0d, want 13", lat);
        else n_pass++;
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== 1000 || got_im[k] !== 0)
                $display("FAIL b2b_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (1000,0)", k, got_idx[k], got_re[k], got_im[k], k);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found = 1'b0;
        g_sel = 1'b0;
        start_frame('{8000, 0, 0, 0, 0, 0, 0, 0});
        wait_valid();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_valid && m_idx == 3'd5) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!found || {busy0, valid0, idx0, re0, im0} !== 38'd0)
            $display("FAIL reset_mid_out: got found=%b busy=%b valid=%b idx=%0d re=%0d im=%0d, want 1 and all 0", found, busy0, valid0, idx0, re0, im0);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        start_frame('{8000, 0, 0, 0, 0, 0, 0, 0});
        wait_valid();
        n_checks++;
        if (lat !== 13) $display("FAIL post_reset_latency: got %0d, want 13", lat);
        else n_pass++;
        collect();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_idx[k] !== k || got_re[k] !== 1000 || got_im[k] !== 0)
                $display("FAIL post_reset_bin%0d: got idx=%0d (%0d,%0d), want idx=%0d (1000,0)", k, got_idx[k], got_re[k], got_im[k], k);
            else n_pass++;
        end
    endtask

    initial begin
        g_sel = 1'b0;
        test_reset();
        test_impulse();
        test_dc();
        test_nyquist();
        test_offset_binary();
        test_backpressure();
        test_ignored_start();
        test_start_at_last();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
